// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-access stage
package mem_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - access wait counter with clear, enable and expire
module mem_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clear holds the counter at zero so each access starts fresh
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Expire on the enabled edge that would take the count to LIMIT
  assign expire = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: data-memory port, branch resolve, writeback (MEM_TIMEOUT_EN adds access abort)
module mem_stage #(
  parameter int DATA_W         = mem_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      zeroOut,
  input  logic [DATA_W-1:0]         acOutValue,
  input  logic [DATA_W-1:0]         ulaJumpOut,
  input  logic [DATA_W-1:0]         rs,
  input  logic [mem_pkg::REG_W-1:0] rdOut,
  input  logic                      WRMem,
  input  logic                      WMMem,
  input  logic                      RMMem,
  input  logic                      NEQMem,
  input  logic                      JMem,
  input  logic                      JCMem,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic                      stall,
  output logic                      pc_src,
  output logic [DATA_W-1:0]         pc_target,
  output logic                      wb_we,
  output logic [mem_pkg::REG_W-1:0] wb_rd,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      mem_err
);

  import mem_pkg::*;

  memState_t        state;
  memState_t        nextState;
  logic             memOp;
  logic             branchTaken;
  logic             timeoutHit;
  logic             latWr;
  logic [REG_W-1:0] latRd;

  // A store wins when both RM and WM are set, so any memory bit starts an access
  assign memOp       = RMMem | WMMem;
  assign branchTaken = JMem | (JCMem & (zeroOut ^ NEQMem));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode: ack has priority over watchdog expiry
  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (memOp) nextState = ACCESS;
      ACCESS: if (mem_ack || timeoutHit) nextState = IDLE;
    endcase
  end

  // Stall comes straight from the state flop so it is glitch-free and drops with reset
  assign stall = (state == ACCESS);

  // Memory port, branch and writeback registers; pulses default low every edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc_src    <= 1'b0;
      pc_target <= '0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      latWr     <= 1'b0;
      latRd     <= '0;
    end else begin
      pc_src <= 1'b0;
      wb_we  <= 1'b0;
      case (state)
        IDLE: begin
          pc_src    <= branchTaken;
          pc_target <= ulaJumpOut;
          if (memOp) begin
            mem_req   <= 1'b1;
            mem_we    <= WMMem;
            mem_addr  <= acOutValue;
            mem_wdata <= rs;
            latWr     <= WRMem;
            latRd     <= rdOut;
          end else begin
            wb_we   <= WRMem;
            wb_rd   <= rdOut;
            wb_data <= acOutValue;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            wb_we   <= latWr;
            wb_rd   <= latRd;
            wb_data <= mem_we ? mem_addr : mem_rdata;
          end else if (timeoutHit) begin
            mem_req <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic memErrQ;

  mem_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) uWatchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .enable  (state == ACCESS),
    .expire  (timeoutHit)
  );

  // Abort pulse only when expiry is not rescued by a same-edge ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      memErrQ <= 1'b0;
    end else begin
      memErrQ <= (state == ACCESS) && !mem_ack && timeoutHit;
    end
  end

  assign mem_err = memErrQ;
`else
  logic [31:0] unusedTimeout;

  assign unusedTimeout = TIMEOUT_CYCLES;
  assign timeoutHit    = 1'b0;
  assign mem_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       zeroOut;
  logic [7:0] acOutValue;
  logic [7:0] ulaJumpOut;
  logic [7:0] rs;
  logic [1:0] rdOut;
  logic       WRMem, WMMem, RMMem, NEQMem, JMem, JCMem;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;
  logic       stall, pc_src;
  logic [7:0] pc_target;
  logic       wb_we;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       mem_err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .zeroOut    (zeroOut),
    .acOutValue (acOutValue),
    .ulaJumpOut (ulaJumpOut),
    .rs         (rs),
    .rdOut      (rdOut),
    .WRMem      (WRMem),
    .WMMem      (WMMem),
    .RMMem      (RMMem),
    .NEQMem     (NEQMem),
    .JMem       (JMem),
    .JCMem      (JCMem),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall      (stall),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mem_err    (mem_err)
  );

  typedef struct {
    logic       we;
    logic [1:0] rd;
    logic [7:0] data;
    logic       chkData;
    logic       pc;
    logic [7:0] tgt;
  } exp_t;

  typedef struct {
    logic       wr, wm, rm, neq, j, jc, zero;
    logic [1:0] rd;
    logic [7:0] ac, jt, rsv;
    logic       eWe;
    logic [1:0] eRd;
    logic [7:0] eData;
    logic       ePc;
    logic [7:0] eTgt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic setInstr(input logic wr, wm, rm, neq, j, jc, zero,
                          input logic [1:0] rd, input logic [7:0] ac, jt, rsv);
    WRMem = wr; WMMem = wm; RMMem = rm; NEQMem = neq;
    JMem = j; JCMem = jc; zeroOut = zero;
    rdOut = rd; acOutValue = ac; ulaJumpOut = jt; rs = rsv;
  endtask

  task automatic checkWb(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
      return;
    end
    e = sb.pop_front();
    chk({name, "_wb_we"}, wb_we, e.we);
    if (e.chkData) begin
      chk({name, "_wb_rd"}, wb_rd, e.rd);
      chk({name, "_wb_data"}, wb_data, e.data);
    end
    chk({name, "_pc_src"}, pc_src, e.pc);
    if (e.pc) chk({name, "_pc_target"}, pc_target, e.tgt);
  endtask

  task automatic memSeq(input string nm, input logic rm, wm, wr, j,
                        input logic [1:0] rd, input logic [7:0] ac, rsv, rdata, input int k);
    int   stallCycles;
    logic earlyWb;
    exp_t e;
    stallCycles = 0;
    earlyWb     = 1'b0;
    @(negedge clock);
    setInstr(wr, wm, rm, 1'b0, j, 1'b0, 1'b0, rd, ac, 8'h60, rsv);
    mem_ack = 1'b0;
    e = '{we: wr, rd: rd, data: (wm ? ac : rdata), chkData: wr, pc: 1'b0, tgt: 8'h00};
    sb.push_back(e);
    @(posedge clock); #1;
    chk({nm, "_req"}, mem_req, 1'b1);
    chk({nm, "_we"}, mem_we, wm);
    chk({nm, "_addr"}, mem_addr, ac);
    if (wm) chk({nm, "_wdata"}, mem_wdata, rsv);
    chk({nm, "_stall"}, stall, 1'b1);
    chk({nm, "_pc_src_accept"}, pc_src, j);
    if (j) chk({nm, "_pc_target_accept"}, pc_target, 8'h60);
    if (stall) stallCycles++;
    if (wb_we) earlyWb = 1'b1;
    for (int c = 1; c <= k; c++) begin
      @(negedge clock);
      if (c == 1) setInstr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h5A, 8'h00, 8'h00);
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? rdata : 8'h00;
      @(posedge clock); #1;
      if (c < k) begin
        if (stall) stallCycles++;
        if (wb_we) earlyWb = 1'b1;
      end
    end
    checkWb(nm);
    chk({nm, "_stall_cycles"}, stallCycles, k);
    chk({nm, "_no_early_wb"}, earlyWb, 1'b0);
    chk({nm, "_stall_done"}, stall, 1'b0);
    chk({nm, "_req_done"}, mem_req, 1'b0);
    chk({nm, "_addr_held"}, mem_addr, ac);
    chk({nm, "_err"}, mem_err, 1'b0);
    @(negedge clock);
    mem_ack = 1'b0;
    e = '{we: 1'b1, rd: 2'd3, data: 8'h5A, chkData: 1'b1, pc: 1'b0, tgt: 8'h00};
    sb.push_back(e);
    @(posedge clock); #1;
    checkWb({nm, "_next"});
    chk({nm, "_next_req"}, mem_req, 1'b0);
    @(negedge clock);
    setInstr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vecs[0] = '{1,0,0,0,0,0,0, 2'd2, 8'h3C, 8'h00, 8'h00, 1, 2'd2, 8'h3C, 0, 8'h00};
    vecs[1] = '{0,0,0,1,0,1,0, 2'd0, 8'h05, 8'h40, 8'h00, 0, 2'd0, 8'h05, 1, 8'h40};
    vecs[2] = '{0,0,0,1,0,1,1, 2'd0, 8'h06, 8'h41, 8'h00, 0, 2'd0, 8'h06, 0, 8'h00};
    vecs[3] = '{1,0,0,0,0,1,1, 2'd1, 8'h07, 8'h50, 8'h00, 1, 2'd1, 8'h07, 1, 8'h50};
    vecs[4] = '{1,0,0,0,1,0,0, 2'd1, 8'hAA, 8'h99, 8'h00, 1, 2'd1, 8'hAA, 1, 8'h99};
    vecs[5] = '{0,0,0,0,0,1,0, 2'd3, 8'hBB, 8'h12, 8'h00, 0, 2'd3, 8'hBB, 0, 8'h00};
    vecs[6] = '{0,0,0,1,0,0,1, 2'd0, 8'h00, 8'h13, 8'h00, 0, 2'd0, 8'h00, 0, 8'h00};
    vecs[7] = '{1,0,0,0,0,0,0, 2'd3, 8'hFF, 8'h00, 8'h00, 1, 2'd3, 8'hFF, 0, 8'h00};

    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    setInstr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pc_src", pc_src, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_pc_target", pc_target, 8'h00);
    chk("rst_wb_rd", wb_rd, 2'd0);
    chk("rst_wb_data", wb_data, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // Single-cycle instructions; ack held high in IDLE must be ignored
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      setInstr(vecs[i].wr, vecs[i].wm, vecs[i].rm, vecs[i].neq, vecs[i].j, vecs[i].jc,
               vecs[i].zero, vecs[i].rd, vecs[i].ac, vecs[i].jt, vecs[i].rsv);
      e = '{we: vecs[i].eWe, rd: vecs[i].eRd, data: vecs[i].eData, chkData: 1'b1,
            pc: vecs[i].ePc, tgt: vecs[i].eTgt};
      sb.push_back(e);
      @(posedge clock); #1;
      checkWb($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_stall", i), stall, 1'b0);
      chk($sformatf("vec%0d_req", i), mem_req, 1'b0);
    end
    @(negedge clock);
    mem_ack = 1'b0;
    setInstr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);

    memSeq("load", 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h10, 8'h00, 8'hA5, 3);
    memSeq("store", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'h20, 8'h77, 8'h00, 1);
    memSeq("rmwm", 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h33, 8'h44, 8'hC3, 2);

    // Reset asserted two cycles into a load
    @(negedge clock);
    setInstr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h12, 8'h00, 8'h00);
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rstacc_req", mem_req, 1'b0);
    chk("rstacc_stall", stall, 1'b0);
    @(negedge clock);
    setInstr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk($sformatf("rstacc_no_wb%0d", c), wb_we, 1'b0);
      chk($sformatf("rstacc_idle_req%0d", c), mem_req, 1'b0);
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int   n;
      logic done;
      n    = 0;
      done = 1'b0;
      @(negedge clock);
      setInstr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h21, 8'h00, 8'h00);
      mem_ack = 1'b0;
      @(posedge clock); #1;
      if (stall) n++;
      @(negedge clock);
      setInstr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      for (int c = 0; c < 40 && !done; c++) begin
        @(posedge clock); #1;
        if (mem_err) done = 1'b1;
        else if (stall) n++;
      end
      chk("tmo_seen", done, 1'b1);
      chk("tmo_wait_cycles", n, 15);
      chk("tmo_req", mem_req, 1'b0);
      chk("tmo_stall", stall, 1'b0);
      chk("tmo_no_wb", wb_we, 1'b0);
      @(posedge clock); #1;
      chk("tmo_err_pulse", mem_err, 1'b0);
      chk("tmo_no_wb_after", wb_we, 1'b0);
    end
    memSeq("ackwins", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h30, 8'h00, 8'h5C, 15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 8-bit pipeline, sitting directly after the execute stage and consuming its registered outputs: ALU result, zero flag, jump target, store data, destination register and the WR/WM/RM/NEQ/J/JC control bits. It drives a request/acknowledge data-memory port and resolves branches toward fetch. It stalls the upstream pipeline while an access is outstanding and presents a registered writeback bundle to the register file.

## Interface
- DATA_W, 8, datapath and address width
- TIMEOUT_CYCLES, 15, wait cycles before an access is aborted (MEM_TIMEOUT_EN only)

- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- zeroOut  in  1  ALU zero flag from execute
- acOutValue  in  8  ALU result; memory address for loads and stores
- ulaJumpOut  in  8  branch/jump target
- rs  in  8  store data
- rdOut  in  2  destination register
- WRMem, WMMem, RMMem, NEQMem, JMem, JCMem  in  1 each  control bits from execute
- mem_req  out  1  registered access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  8  latched address
- mem_wdata  out  8  latched store data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  access complete
- stall  out  1  freeze execute and earlier stages
- pc_src  out  1  one-cycle pulse: redirect fetch (also the flush request)
- pc_target  out  8  redirect address
- wb_we  out  1  one-cycle register-write pulse
- wb_rd  out  2  writeback register
- wb_data  out  8  writeback value
- mem_err  out  1  one-cycle pulse on aborted access

## Operation
- States: IDLE and ACCESS.
- In IDLE, the stage evaluates its inputs every edge.
  - RM|WM: latch address (acOutValue), store data (rs), mem_we=WM, rdOut and WRMem, then go to ACCESS. mem_req rises.
  - Branch: pc_src <= JMem | (JCMem & (zeroOut ^ NEQMem)); pc_target <= ulaJumpOut. This is evaluated even when a memory op is accepted on the same edge.
  - No memory op: wb_we <= WRMem, wb_rd <= rdOut, wb_data <= acOutValue.
  - RM and WM both set: treated as a write.
- ACCESS
  - mem_req and stall are held at 1. Execute-stage inputs are ignored and held stable by upstream.
  - mem_ack sampled high: drop mem_req and return to IDLE.
    - Read: wb_data <= mem_rdata.
    - Write: wb_data <= latched address.
    - In both cases wb_we <= latched WR and wb_rd <= latched rd.
- mem_ack in IDLE is ignored.
- stall = (state == ACCESS), decoded from state and glitch-free.

## Timing
- Reset values: state IDLE; mem_req, mem_we, stall, pc_src, wb_we and mem_err are 0; mem_addr, mem_wdata, pc_target, wb_rd and wb_data are 0.
- Non-memory instruction: writeback and branch outputs valid 1 cycle after the inputs are presented.
- Memory access with ack on wait cycle k (k ≥ 1 after mem_req rises): wb pulse at k+1, stall low at k+1, so total occupancy is k+1 cycles.
- The instruction following a memory op is held at the inputs during ACCESS and is evaluated on the first IDLE edge.
- pc_src, wb_we and mem_err are always single-cycle pulses.
- Asserting reset_n low mid-ACCESS drops mem_req and stall immediately, with no writeback. The memory must tolerate a request withdrawn without ack.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When the count reaches TIMEOUT_CYCLES without ack, the stage returns to IDLE, drops mem_req, pulses mem_err, and suppresses wb_we.
  - If ack and expiry occur on the same edge, ack wins.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err is tied to 0. The port list is identical in both builds.

## Structure
- Package mem_pkg: state enum (IDLE, ACCESS), DATA_W and REG_W (2) constants.
- One sub-module, mem_watchdog: counter with clear, enable and expire outputs, instantiated only under MEM_TIMEOUT_EN.

## Test plan
- ALU op: WRMem=1, rdOut=2, acOutValue=8'h3C → next cycle wb_we=1, wb_rd=2, wb_data=8'h3C; stall stays 0.
- Load: RMMem=1, WRMem=1, acOutValue=8'h10, ack after 3 wait cycles with mem_rdata=8'hA5 → mem_addr=8'h10, stall high for 3 cycles, then wb_data=8'hA5 written to rdOut.
- Store: WMMem=1, rs=8'h77, acOutValue=8'h20, ack on first wait cycle → mem_we=1, mem_wdata=8'h77, no wb_we.
- Conditional jump: JCMem=1, NEQMem=1, zeroOut=0, ulaJumpOut=8'h40 → pc_src pulse with pc_target=8'h40. Repeat with zeroOut=1 → no pc_src.
- Reset in ACCESS: drop reset_n two cycles into a load → mem_req and stall go 0 asynchronously; no wb_we after release.
- MEM_TIMEOUT_EN build: no ack for 15 cycles → mem_err pulse, mem_req 0, state IDLE, no wb_we.
